// File: rtl/vc_wbuf.sv
// vc_wbuf: posted write buffer with tail merging and drain-before-read ordering
// between the vc CPU core and the 8-bit external bus bridge.
module vc_wbuf #(
    parameter int DEPTH = 4,
    parameter int RV    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [14:0]   raddr,
    input  logic          rreq,
    output logic [RV-1:0] rdata,
    output logic          rdone,
    input  logic [14:0]   waddr,
    input  logic [1:0]    wmask,
    input  logic [RV-1:0] wdata,
    output logic          wdone,
    output logic [14:0]   m_raddr,
    output logic          m_rreq,
    input  logic [RV-1:0] m_rdata,
    input  logic          m_rdone,
    output logic [14:0]   m_waddr,
    output logic [1:0]    m_wmask,
    output logic [RV-1:0] m_wdata,
    input  logic          m_wdone,
    output logic          wb_empty
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_WAIT, R_DONE} rstate_t;

    rstate_t       rs, rs_n;
    logic [14:0]   addr_q [DEPTH];
    logic [1:0]    mask_q [DEPTH];
    logic [RV-1:0] data_q [DEPTH];
    logic [14:0]   addr_n [DEPTH];
    logic [1:0]    mask_n [DEPTH];
    logic [RV-1:0] data_n [DEPTH];
    logic [AW-1:0] head, tail, last, head_n, idx;
    logic [AW:0]   count, count_n;
    logic          merge, accept, push, pop;

    // The tail entry is only mergeable once it is no longer the in-flight head.
    assign last    = tail - AW'(1);
    assign merge   = count >= (AW+1)'(2) && waddr == addr_q[last];
    assign accept  = |wmask && !wdone && (rs == R_IDLE || rs == R_DONE)
                     && (count < (AW+1)'(DEPTH) || merge);
    assign push    = accept && !merge;
    assign pop     = m_wdone && count != '0;
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    assign head_n  = head + AW'(pop);
    assign idx     = merge ? last : tail;

    always_comb begin
        addr_n = addr_q;
        mask_n = mask_q;
        data_n = data_q;
        if (accept) begin
            addr_n[idx]         = waddr;
            mask_n[idx]         = merge ? mask_q[idx] | wmask : wmask;
            data_n[idx][7:0]    = (wmask[0] || !merge) ? wdata[7:0] : data_q[idx][7:0];
            data_n[idx][RV-1:8] = (wmask[1] || !merge) ? wdata[RV-1:8] : data_q[idx][RV-1:8];
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_n;
        mask_q <= mask_n;
        data_q <= data_n;
    end

    always_comb begin
        rs_n = rs;
        case (rs)
            R_IDLE:  if (rreq && !rdone) rs_n = R_DRAIN;
            R_DRAIN: if (count == '0 && !accept) rs_n = R_WAIT;
            R_WAIT:  if (m_rdone) rs_n = R_DONE;
            default: rs_n = R_IDLE;
        endcase
    end

    // Bridge outputs are loaded from the post-edge FIFO view so they never go stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs       <= R_IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wdone    <= 1'b0;
            m_waddr  <= '0;
            m_wmask  <= '0;
            m_wdata  <= '0;
            wb_empty <= 1'b1;
            m_raddr  <= '0;
            m_rreq   <= 1'b0;
            rdata    <= '0;
            rdone    <= 1'b0;
        end else begin
            rs       <= rs_n;
            head     <= head_n;
            tail     <= tail + AW'(push);
            count    <= count_n;
            wdone    <= accept;
            m_wmask  <= count_n != '0 ? mask_n[head_n] : 2'b00;
            wb_empty <= count_n == '0;
            rdone    <= rs == R_WAIT && m_rdone;
            if (count_n != '0) begin
                m_waddr <= addr_n[head_n];
                m_wdata <= data_n[head_n];
            end
            if (rs == R_WAIT && m_rdone) begin
                rdata  <= m_rdata;
                m_rreq <= 1'b0;
            end
            if (rs == R_DRAIN && rs_n == R_WAIT) begin
                m_raddr <= raddr;
                m_rreq  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vc_wbuf.sv
// tb_vc_wbuf: queue-based reference model of the write buffer, per-cycle output
// monitor and read-data scoreboard, directed scenarios plus randomized traffic.
module tb_vc_wbuf;
    localparam int DEPTH = 4;

    logic        clk = 0, rst_n = 0;
    logic [14:0] raddr = 0, waddr = 0, m_raddr, m_waddr;
    logic        rreq = 0, rdone, wdone, m_rreq, m_rdone = 0, m_wdone = 0, wb_empty;
    logic [15:0] rdata, wdata = 0, m_rdata = 0, m_wdata;
    logic [1:0]  wmask = 0, m_wmask;

    always #5 clk = ~clk;

    vc_wbuf #(.DEPTH(DEPTH), .RV(16)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rreq(rreq), .rdata(rdata), .rdone(rdone),
        .waddr(waddr), .wmask(wmask), .wdata(wdata), .wdone(wdone),
        .m_raddr(m_raddr), .m_rreq(m_rreq), .m_rdata(m_rdata), .m_rdone(m_rdone),
        .m_waddr(m_waddr), .m_wmask(m_wmask), .m_wdata(m_wdata), .m_wdone(m_wdone),
        .wb_empty(wb_empty)
    );

    typedef struct {
        logic [14:0] a;
        logic [1:0]  m;
        logic [15:0] d;
    } ent_t;

    ent_t        wq[$];
    logic [15:0] rq[$];
    logic [14:0] drained[$];
    int          vecs = 0, errs = 0;
    bit          wd_e = 0, rdone_e = 0, rreq_e = 0, logging = 0;
    logic [14:0] raddr_e = 0;
    logic [15:0] rdata_e = 0;
    int          rst_e = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    // Reference model: the buffer is a queue of entries; reads wait for it to empty.
    always @(posedge clk or negedge rst_n) begin
        int   cnt;
        bit   mrg, acc, rd_old;
        ent_t e;
        if (!rst_n) begin
            wq.delete();
            rq.delete();
            wd_e = 0; rdone_e = 0; rreq_e = 0; raddr_e = 0; rdata_e = 0; rst_e = 0;
        end else begin
            cnt = wq.size();
            mrg = cnt >= 2 && wq[cnt-1].a == waddr;
            acc = wmask != 0 && !wd_e && (rst_e == 0 || rst_e == 3) && (cnt < DEPTH || mrg);
            rd_old = rdone_e;
            rdone_e = 0;
            case (rst_e)
                0: if (rreq && !rd_old) rst_e = 1;
                1: if (cnt == 0 && !acc) begin rst_e = 2; rreq_e = 1; raddr_e = raddr; end
                2: if (m_rdone) begin
                       rst_e = 3; rreq_e = 0; rdone_e = 1; rdata_e = m_rdata;
                       rq.push_back(m_rdata);
                   end
                default: rst_e = 0;
            endcase
            if (acc && mrg) begin
                e = wq[cnt-1];
                if (wmask[0]) e.d[7:0] = wdata[7:0];
                if (wmask[1]) e.d[15:8] = wdata[15:8];
                e.m = e.m | wmask;
                wq[cnt-1] = e;
            end else if (acc) begin
                e.a = waddr; e.m = wmask; e.d = wdata;
                wq.push_back(e);
            end
            if (m_wdone && cnt > 0) void'(wq.pop_front());
            wd_e = acc;
        end
    end

    // Monitor: compares every cycle, pops the read scoreboard on each rdone pulse.
    always @(negedge clk) begin
        logic [15:0] r;
        chk("wdone", wdone, wd_e);
        chk("m_wmask", m_wmask, wq.size() ? wq[0].m : 2'b00);
        if (wq.size()) begin
            chk("m_waddr", m_waddr, wq[0].a);
            chk("m_wdata", m_wdata, wq[0].d);
        end
        chk("wb_empty", wb_empty, wq.size() == 0);
        chk("m_rreq", m_rreq, rreq_e);
        if (rreq_e) chk("m_raddr", m_raddr, raddr_e);
        chk("rdone", rdone, rdone_e);
        chk("rdata", rdata, rdata_e);
        if (rdone) begin
            if (rq.size() == 0) chk("rdone_unexpected", 1, 0);
            else begin
                r = rq.pop_front();
                chk("rdata_sb", rdata, r);
            end
        end
        if (logging && m_wdone && m_wmask != 0) drained.push_back(m_waddr);
    end

    task automatic write_op(input logic [14:0] a, input logic [1:0] m, input logic [15:0] d,
                            output int lat);
        waddr = a; wmask = m; wdata = d; lat = 0;
        do begin @(negedge clk); lat++; end while (!wdone && lat < 200);
        if (!wdone) chk("write_timeout", 0, 1);
        wmask = 0;
    endtask

    task automatic pulse_wdone();
        m_wdone = 1;
        @(negedge clk);
        m_wdone = 0;
    endtask

    initial begin
        int lat, n;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        // single write
        write_op(15'h1234, 2'b11, 16'hBEEF, lat);
        chk("single_lat", lat, 1);
        @(negedge clk);
        chk("single_addr", m_waddr, 15'h1234);
        chk("single_mask", m_wmask, 2'b11);
        chk("single_data", m_wdata, 16'hBEEF);
        pulse_wdone();
        chk("single_done_mask", m_wmask, 0);
        chk("single_empty", wb_empty, 1);
        // fill and stall
        for (int i = 0; i < 4; i++) write_op(15'h100 + 15'(i), 2'b11, 16'hC000 + 16'(i), lat);
        waddr = 15'h104; wmask = 2'b11; wdata = 16'hC004;
        repeat (4) begin @(negedge clk); chk("full_stall", wdone, 0); end
        pulse_wdone();
        chk("full_stall_pop", wdone, 0);
        @(negedge clk);
        chk("fifth_accept", wdone, 1);
        chk("fifth_head", m_waddr, 15'h101);
        wmask = 0;
        m_wdone = 1;
        repeat (6) @(negedge clk);
        m_wdone = 0;
        chk("fill_drained", wb_empty, 1);
        // merge behind in-flight head
        write_op(15'h0001, 2'b11, 16'h1111, lat);
        write_op(15'h0010, 2'b01, 16'h00AA, lat);
        write_op(15'h0010, 2'b10, 16'hBB00, lat);
        pulse_wdone();
        chk("merge_addr", m_waddr, 15'h0010);
        chk("merge_mask", m_wmask, 2'b11);
        chk("merge_data", m_wdata, 16'hBBAA);
        chk("merge_not_empty", wb_empty, 0);
        pulse_wdone();
        chk("merge_one_entry", wb_empty, 1);
        // read waits for drain
        write_op(15'h0030, 2'b11, 16'h0001, lat);
        write_op(15'h0031, 2'b11, 16'h0002, lat);
        raddr = 15'h0020; rreq = 1;
        repeat (3) begin @(negedge clk); chk("read_held", m_rreq, 0); end
        pulse_wdone();
        chk("read_held1", m_rreq, 0);
        pulse_wdone();
        n = 0;
        while (!m_rreq && n < 20) begin @(negedge clk); n++; end
        chk("read_issue", m_rreq, 1);
        chk("read_addr", m_raddr, 15'h0020);
        m_rdata = 16'h5A5A; m_rdone = 1;
        @(negedge clk);
        m_rdone = 0;
        chk("read_done", rdone, 1);
        chk("read_data", rdata, 16'h5A5A);
        rreq = 0;
        @(negedge clk);
        chk("read_pulse", rdone, 0);
        // reset mid-drain
        for (int i = 0; i < 3; i++) write_op(15'h40 + 15'(i), 2'b11, 16'h7000 + 16'(i), lat);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_wmask", m_wmask, 0);
        chk("rst_empty", wb_empty, 1);
        chk("rst_waddr", m_waddr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_wdone", wdone, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_after_empty", wb_empty, 1);
        chk("rst_after_mask", m_wmask, 0);
        // pointer wrap with immediate drain
        m_wdone = 1; logging = 1;
        for (int i = 0; i < 10; i++) write_op(15'h200 + 15'(i), 2'b11, 16'hA000 + 16'(i), lat);
        repeat (3) @(negedge clk);
        logging = 0; m_wdone = 0;
        chk("wrap_count", drained.size(), 10);
        for (int i = 0; i < 10 && i < drained.size(); i++) chk("wrap_order", drained[i], 15'h200 + 15'(i));
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (wmask != 0 && wdone) wmask = 0;
            else if (wmask == 0 && $urandom % 3 == 0) begin
                waddr = 15'($urandom_range(0, 3));
                wmask = 2'($urandom_range(1, 3));
                wdata = 16'($urandom);
            end
            if (rreq && rdone) rreq = 0;
            else if (!rreq && !rdone && $urandom % 20 == 0) begin
                rreq = 1;
                raddr = 15'($urandom);
            end
            m_wdone = 1'($urandom % 2);
            m_rdone = $urandom % 3 == 0;
            m_rdata = 16'($urandom);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wdone) wmask = 0;
            if (rdone) rreq = 0;
            m_wdone = 1; m_rdone = 1;
        end
        m_wdone = 0; m_rdone = 0;
        @(negedge clk);
        chk("final_empty", wb_empty, 1);
        chk("final_rq", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/vc_wbuf.md
Name: vc_wbuf

Overview:
Posted write buffer between the vc CPU core and the 8-bit external bus bridge. It accepts CPU writes into a small FIFO and acknowledges them quickly, then drains them to the bridge one entry at a time. CPU reads are held until the buffer has fully drained, which keeps memory and I/O ordering strict. Adjacent writes to the same word are merged into one entry.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2.
RV, 16, data width; the word address is [15:1].

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
raddr  in  15  CPU read word address
rreq  in  1  CPU read request; held until rdone
rdata  out  16  read data; valid while rdone=1
rdone  out  1  one-cycle read completion pulse
waddr  in  15  CPU write word address
wmask  in  2  byte enables; bit0 = [7:0], bit1 = [15:8]; nonzero means write request
wdata  in  16  CPU write data
wdone  out  1  one-cycle write acceptance pulse
m_raddr  out  15  read address to the bridge
m_rreq  out  1  read request to the bridge
m_rdata  in  16  read data from the bridge
m_rdone  in  1  read done pulse from the bridge
m_waddr  out  15  write address to the bridge
m_wmask  out  2  write byte enables to the bridge; nonzero means request
m_wdata  out  16  write data to the bridge
m_wdone  in  1  write done pulse from the bridge
wb_empty  out  1  high when count==0 and no write is in flight

Behaviour:
- Reset (asynchronous, rst_n low):
  - rdone=0, wdone=0, m_rreq=0, m_wmask=0, rdata=0, count=0.
  - m_raddr, m_waddr and m_wdata reset to 0.
  - wb_empty=1. Read FSM goes to R_IDLE.
  - Buffered writes are discarded. Reset mid-drain or mid-read abandons the operation with no pulse generated.
- All outputs are registered.
- Write accept:
  - A write is accepted on an edge where wmask!=0, wdone==0, and either count<DEPTH or a merge applies.
  - wdone=1 for exactly the next cycle. The CPU changes or drops its request during that cycle; no accept is taken while wdone=1.
- Merge:
  - Applies when count>=2 and waddr equals the tail entry address.
  - The tail entry's bytes are overwritten per wmask, and its mask becomes old_mask | wmask.
  - count does not change. Merge is allowed even when the buffer is full.
  - No merge is done when count==1, because the tail is then the in-flight head.
- Push: otherwise the write is pushed at the tail and the tail pointer wraps modulo DEPTH.
- Full: when count==DEPTH and there is no merge, the write stalls. wdone stays 0 until a pop frees a slot; accept happens on the first edge where count<DEPTH.
- Drain:
  - m_waddr, m_wmask and m_wdata present the head entry whenever count>0; otherwise m_wmask=0.
  - On the edge where m_wdone=1, the head is popped. At that same edge m_* are loaded with the next entry, or m_wmask goes to 0. The bridge never sees a stale request.
- Simultaneous push and pop: both happen and count is unchanged.
- Count: 0..DEPTH with no overflow. Pointers are log2(DEPTH) bits and wrap.
- Read FSM states:
  - R_IDLE: on rreq=1 and rdone=0, go to R_DRAIN.
  - R_DRAIN: wait for count==0, with no accept pending in the same cycle. Then set m_raddr=raddr and m_rreq=1, and go to R_WAIT.
  - R_WAIT: on m_rdone=1, set rdata=m_rdata, rdone=1 and m_rreq=0, and go to R_DONE.
  - R_DONE: set rdone=0 and go to R_IDLE.
- Read priority: while in R_DRAIN or R_WAIT, new CPU writes are not accepted (the CPU is single-issue; this is enforced anyway).
- Read latency: 2 cycles plus the bridge latency when the buffer is empty.

Test Plan:
- Single write: addr 0x1234, mask 11, data 0xBEEF into an empty buffer → wdone pulses 1 cycle after the request. Next cycle m_waddr=0x1234, m_wmask=11, m_wdata=0xBEEF. After m_wdone: m_wmask=0, wb_empty=1.
- Fill: 5 writes to distinct addresses with m_wdone held low, DEPTH=4 → 4 wdone pulses, 5th stalls. A single m_wdone pulse pops entry 0 and the 5th is accepted the next cycle. Drain order is FIFO.
- Merge: with head in flight, write 0x0010 mask 01 data 0x00AA, then 0x0010 mask 10 data 0xBB00 → a single entry with mask 11, data 0xBBAA, count=2.
- Read after writes: 2 writes pending, then rreq at 0x0020 → m_rreq stays 0 until both m_wdone pulses. Bridge returns 0x5A5A → rdata=0x5A5A with a 1-cycle rdone pulse.
- Reset mid-drain: rst_n low with 3 entries and m_wmask!=0 → all outputs reach reset values immediately and the buffer is empty after release.
- Pointer wrap: 10 writes with immediate m_wdone → addresses and data emerge in order with correct wrap, and no lost or duplicated entries.
